// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: holds the architectural PC and runs instruction fetch.
// It keeps at most one imem request in flight. The if_* output slot is
// backed by a one-entry skid buffer, so a zero-wait memory can deliver one
// instruction per cycle. Execute-stage redirects go through a drain state
// when a request is still outstanding.
// Optional feature: define PC_MISALIGN_TRAP_EN to add the misalign_trap and
// trap_addr outputs and a TRAP state for misaligned redirect targets.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  br_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] imm,
  input  logic [31:0] op1,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        flush
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap,
  output logic [31:0] trap_addr
`endif
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [3:0]  BOOT_LAST = 4'(BOOT_DELAY - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        flush_q, flush_d;
  logic        trap_q, trap_d;

  logic [31:0] target_raw;
  logic [31:0] target;
  logic        misaligned;
  logic        redirect;
  logic        slot_free;
  logic        consume;

  // Compute the redirect target from the execute-stage operands.
  always_comb begin
    target_raw = ex_pc + imm;
    if (br_taken == 2'd2) begin
      target_raw = (op1 + imm) & ~32'h1;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign target     = target_raw;
  assign misaligned = (target_raw[1:0] != 2'b00);
`else
  assign target     = target_raw & ~32'h3;
  assign misaligned = 1'b0;
`endif

  assign redirect  = ((br_taken == 2'd1) || (br_taken == 2'd2)) && (state_q != S_BOOT);
  assign slot_free = !valid_q || !stall;
  assign consume   = valid_q && !stall;

  // Compute the next state, the datapath updates and the fetch request.
  always_comb begin
    // NOTE: every signal gets a default first, so that no path through the case can leave one unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q && stall;
    inst_d       = inst_q;
    ifpc_d       = ifpc_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    drain_addr_d = drain_addr_q;
    flush_d      = 1'b0;
    trap_d       = trap_q;
    imem_req     = 1'b0;
    imem_addr    = pc_q;

    unique case (state_q)
      S_BOOT: begin
        if (cnt_q >= BOOT_LAST) state_d = S_FETCH;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_d = pc_q + 32'd4;
          if (slot_free) begin
            valid_d = 1'b1;
            inst_d  = imem_rdata;
            ifpc_d  = pc_q;
          end else begin
            skid_d    = imem_rdata;
            skid_pc_d = pc_q;
            state_d   = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (consume) begin
          valid_d = 1'b1;
          inst_d  = skid_q;
          ifpc_d  = skid_pc_q;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr_q;
        if (imem_ack) state_d = trap_q ? S_TRAP : S_FETCH;
      end
      S_TRAP: begin
      end
      default: state_d = S_BOOT;
    endcase

    // A redirect outranks stall and ack. An unacknowledged request must still be drained.
    if (redirect) begin
      valid_d = 1'b0;
      flush_d = 1'b1;
      trap_d  = misaligned;
      pc_d    = target;
      state_d = misaligned ? S_TRAP : S_FETCH;
      if (imem_req && !imem_ack) begin
        state_d = S_DRAIN;
        if (state_q == S_FETCH) drain_addr_d = pc_q;
      end
    end
  end

  // State register for the FSM, the PC, the output slot and the skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      inst_q       <= NOP;
      ifpc_q       <= '0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      drain_addr_q <= RESET_PC;
      flush_q      <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples the values from before this edge.
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      inst_q       <= inst_d;
      ifpc_q       <= ifpc_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      drain_addr_q <= drain_addr_d;
      flush_q      <= flush_d;
      trap_q       <= trap_d;
    end
  end

  assign if_valid = valid_q;
  assign if_inst  = inst_q;
  assign if_pc    = ifpc_q;
  assign flush    = flush_q;

`ifdef PC_MISALIGN_TRAP_EN
  logic [31:0] trap_addr_q;

  // Capture the target of each misaligned redirect that is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       trap_addr_q <= '0;
    else if (redirect && misaligned)  trap_addr_q <= target;
  end

  assign misalign_trap = trap_q;
  assign trap_addr     = trap_addr_q;
`endif

endmodule
